instr_fetch_sequencer: RTL and testbench

- Upstream stage of the ALU/register block: fetches 32-bit instruction words from instruction memory and issues each as an opcode/operand pair.
- Sequences execution: holds a program counter, resolves jumps and flag-conditional jumps locally, and halts on HALT.
- After ALU ops, waits one settle cycle so a following conditional jump sees registered ALU flags.
- Times out on a stalled memory fetch.

---
 rtl/instr_fetch_sequencer_pkg.sv | 41 ++++
 rtl/instr_fetch_sequencer_if.sv | 33 +++
 rtl/instr_fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared constants and types for the instruction fetch sequencer: default widths,
// opcode class nibbles, control sub-codes, the NOP encoding, ALU flag bit positions
// and the FSM state encoding.
package instr_fetch_sequencer_pkg;

   localparam int IFS_DATA_WIDTH = 16;
   localparam int IFS_ADDR_WIDTH = 8;
   localparam int IFS_TIMEOUT    = 255;
   localparam int TIMER_WIDTH    = 8;

   // Opcode class, taken from the top nibble of the opcode
   localparam logic [3:0] CLS_LDI  = 4'h0;
   localparam logic [3:0] CLS_ALU  = 4'h1;
   localparam logic [3:0] CLS_RD   = 4'h2;
   localparam logic [3:0] CLS_JZ   = 4'hD;
   localparam logic [3:0] CLS_JMP  = 4'hE;
   localparam logic [3:0] CLS_CTRL = 4'hF;

   // Control sub-code, taken from the second nibble of a control opcode
   localparam logic [3:0] CTRL_HALT = 4'h0;

   // Opcode presented to the ALU/register stage whenever nothing is issued
   localparam logic [15:0] OPC_NOP = 16'hF100;

   // ALU flag bit positions
   localparam int FLAG_ZERO     = 0;
   localparam int FLAG_CARRY    = 1;
   localparam int FLAG_NEGATIVE = 2;
   localparam int FLAG_OVERFLOW = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DECODE = 3'd3,
      ST_ISSUE  = 3'd4,
      ST_SETTLE = 3'd5,
      ST_HALTED = 3'd6
   } state_t;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Bus bundle between the sequencer, instruction memory and the ALU/register stage.
// The master side is the sequencer; the slave side is the memory/ALU environment.
interface instr_fetch_sequencer_if
   import instr_fetch_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = IFS_DATA_WIDTH,
   parameter int ADDR_WIDTH = IFS_ADDR_WIDTH
);

   // instruction memory
   logic                    imem_req;
   logic [ADDR_WIDTH-1:0]   imem_addr;
   logic                    imem_ack;
   logic [2*DATA_WIDTH-1:0] imem_data;

   // issue port towards the ALU/register stage
   logic [DATA_WIDTH-1:0]   opcode;
   logic [DATA_WIDTH-1:0]   operand;
   logic                    read_enable;
   logic                    issue_valid;
   logic [3:0]              alu_flags;

   modport master (
      output imem_req, imem_addr, opcode, operand, read_enable, issue_valid,
      input  imem_ack, imem_data, alu_flags
   );

   modport slave (
      input  imem_req, imem_addr, opcode, operand, read_enable, issue_valid,
      output imem_ack, imem_data, alu_flags
   );

endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: fetches instruction words, resolves jumps and
// zero-flag conditional jumps locally, issues data/ALU/read instructions to the
// ALU/register stage, inserts a settle cycle after ALU ops and halts on HALT or
// on a memory fetch that is never acknowledged.
module instr_fetch_sequencer
   import instr_fetch_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = IFS_DATA_WIDTH,
   parameter int ADDR_WIDTH = IFS_ADDR_WIDTH,
   parameter int TIMEOUT    = IFS_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   instr_fetch_sequencer_if.master bus,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  halted,
   output logic                  error
);

   // NOP left-aligned so the class nibble stays in the top bits for wider words
   localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(OPC_NOP) << (DATA_WIDTH - 16);
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);

   state_t                    state_reg, state_next;
   logic [ADDR_WIDTH-1:0]     pc_reg, pc_next;
   logic [2*DATA_WIDTH-1:0]   ir_reg, ir_next;
   logic [TIMER_WIDTH-1:0]    timer_reg, timer_next;
   logic                      error_reg, error_next;
   logic [DATA_WIDTH-1:0]     opcode_reg, opcode_next;
   logic [DATA_WIDTH-1:0]     operand_reg, operand_next;
   logic                      read_enable_reg, read_enable_next;
   logic                      issue_valid_reg, issue_valid_next;

   // fields of the latched instruction word
   logic [DATA_WIDTH-1:0]     ir_opcode;
   logic [DATA_WIDTH-1:0]     ir_operand;
   logic [3:0]                ir_class;
   logic [3:0]                ir_sub;
   logic [ADDR_WIDTH-1:0]     ir_target;
   logic [ADDR_WIDTH-1:0]     pc_inc;

   assign ir_opcode  = ir_reg[2*DATA_WIDTH-1 -: DATA_WIDTH];
   assign ir_operand = ir_reg[DATA_WIDTH-1:0];
   assign ir_class   = ir_opcode[DATA_WIDTH-1 -: 4];
   assign ir_sub     = ir_opcode[DATA_WIDTH-5 -: 4];
   assign ir_target  = ir_operand[ADDR_WIDTH-1:0];
   assign pc_inc     = pc_reg + ADDR_WIDTH'(1);

   // State, program counter, instruction register, timeout counter and issue registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         pc_reg          <= '0;
         ir_reg          <= '0;
         timer_reg       <= '0;
         error_reg       <= 1'b0;
         opcode_reg      <= NOP_WORD;
         operand_reg     <= '0;
         read_enable_reg <= 1'b0;
         issue_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         ir_reg          <= ir_next;
         timer_reg       <= timer_next;
         error_reg       <= error_next;
         opcode_reg      <= opcode_next;
         operand_reg     <= operand_next;
         read_enable_reg <= read_enable_next;
         issue_valid_reg <= issue_valid_next;
      end
   end

   // Next-state logic; the issue registers fall back to NOP unless DECODE loads them
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      ir_next          = ir_reg;
      timer_next       = timer_reg;
      error_next       = error_reg;
      opcode_next      = NOP_WORD;
      operand_next     = '0;
      read_enable_next = 1'b0;
      issue_valid_next = 1'b0;

      case (state_reg)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               state_next = ST_FETCH;
               pc_next    = '0;
               error_next = 1'b0;
            end
         end

         ST_FETCH: begin
            state_next = ST_WAIT;
            timer_next = '0;
         end

         ST_WAIT: begin
            if (bus.imem_ack) begin
               ir_next    = bus.imem_data;
               state_next = ST_DECODE;
            end else if (timer_reg == TIMER_LAST) begin
               state_next = ST_HALTED;
               error_next = 1'b1;
            end else begin
               timer_next = timer_reg + TIMER_WIDTH'(1);
            end
         end

         ST_DECODE: begin
            case (ir_class)
               CLS_LDI, CLS_ALU, CLS_RD: begin
                  state_next       = ST_ISSUE;
                  opcode_next      = ir_opcode;
                  operand_next     = ir_operand;
                  read_enable_next = (ir_class == CLS_RD);
                  issue_valid_next = 1'b1;
               end
               CLS_JMP: begin
                  pc_next    = ir_target;
                  state_next = ST_FETCH;
               end
               CLS_JZ: begin
                  pc_next    = bus.alu_flags[FLAG_ZERO] ? ir_target : pc_inc;
                  state_next = ST_FETCH;
               end
               CLS_CTRL: begin
                  if (ir_sub == CTRL_HALT) begin
                     state_next = ST_HALTED;
                  end else begin
                     pc_next    = pc_inc;
                     state_next = ST_FETCH;
                  end
               end
               default: begin
                  // undefined classes are skipped like a NOP
                  pc_next    = pc_inc;
                  state_next = ST_FETCH;
               end
            endcase
         end

         ST_ISSUE: begin
            pc_next    = pc_inc;
            state_next = (ir_class == CLS_ALU) ? ST_SETTLE : ST_FETCH;
         end

         ST_SETTLE: begin
            state_next = ST_FETCH;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.imem_req    = (state_reg == ST_FETCH);
   assign bus.imem_addr   = pc_reg;
   assign bus.opcode      = opcode_reg;
   assign bus.operand     = operand_reg;
   assign bus.read_enable = read_enable_reg;
   assign bus.issue_valid = issue_valid_reg;

   assign pc     = pc_reg;
   assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
   assign halted = (state_reg == ST_HALTED);
   assign error  = error_reg;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: an ISA-level interpreter predicts the fetch
// addresses and issued instructions of each program into queues; a monitor pops
// and compares whenever the DUT requests a fetch or issues an instruction.
module tb_instr_fetch_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pc;
   logic       busy, halted, error;

   instr_fetch_sequencer_if ifc ();

   instr_fetch_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .bus    (ifc),
      .pc     (pc),
      .busy   (busy),
      .halted (halted),
      .error  (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] opc;
      logic [15:0] opd;
      logic        re;
      int          gap;
   } issue_t;

   localparam logic [31:0] W_HALT = 32'hF000_0000;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          fetch_q[$];
   issue_t      issue_q[$];
   logic [31:0] mem[256];
   logic [31:0] ref_mem[256];
   logic [3:0]  flags_val = 4'h0;
   bit          auto_ack = 1'b0;
   bit          inject_ack = 1'b0;
   int          ack_cyc = 0;
   bit          gap_pending = 1'b0;
   int          gap_exp = 0;
   int          issue_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference interpreter: walks the program and records what must be seen
   task automatic model_run(input int start_pc, input int max_steps);
      int          p;
      logic [31:0] w;
      issue_t      e;
      p = start_pc;
      for (int s = 0; s < max_steps; s++) begin
         w = ref_mem[p];
         fetch_q.push_back(p);
         if (w[31:28] <= 4'h2) begin
            e.opc = w[31:16];
            e.opd = w[15:0];
            e.re  = (w[31:28] == 4'h2);
            e.gap = (w[31:28] == 4'h1) ? 2 : 1;
            issue_q.push_back(e);
            p = (p + 1) % 256;
         end else if (w[31:28] == 4'hE) begin
            p = int'(w[7:0]);
         end else if (w[31:28] == 4'hD) begin
            p = flags_val[0] ? int'(w[7:0]) : (p + 1) % 256;
         end else if (w[31:28] == 4'hF && w[27:24] == 4'h0) begin
            return;
         end else begin
            p = (p + 1) % 256;
         end
      end
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) begin
         mem[i]     = W_HALT;
         ref_mem[i] = W_HALT;
      end
   endtask

   task automatic put(input int a, input logic [31:0] w);
      mem[a]     = w;
      ref_mem[a] = w;
   endtask

   task automatic reset_dut(input bit check_values);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      if (check_values) begin
         chk("rst_pc", 32'(pc), 32'h0);
         chk("rst_opcode", 32'(ifc.opcode), 32'hF100);
         chk("rst_operand", 32'(ifc.operand), 32'h0);
         chk("rst_issue_valid", 32'(ifc.issue_valid), 32'h0);
         chk("rst_read_enable", 32'(ifc.read_enable), 32'h0);
         chk("rst_imem_req", 32'(ifc.imem_req), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_halted", 32'(halted), 32'h0);
         chk("rst_error", 32'(error), 32'h0);
      end
      fetch_q.delete();
      issue_q.delete();
      gap_pending = 1'b0;
      reset = 1'b0;
   endtask

   // Returns on the negedge where the first fetch request is visible
   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halted(input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("halt_reached", 32'(halted), 32'h1);
   endtask

   task automatic check_drained();
      chk("fetch_q_drained", 32'(fetch_q.size()), 32'h0);
      chk("issue_q_drained", 32'(issue_q.size()), 32'h0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responder: acknowledges each request after 1..3 cycles
   initial begin
      int a;
      int d;
      ifc.imem_ack  = 1'b0;
      ifc.imem_data = '0;
      forever begin
         @(negedge clk);
         if (inject_ack) begin
            inject_ack    = 1'b0;
            ifc.imem_ack  = 1'b1;
            ifc.imem_data = 32'h0003_00AB;
            @(negedge clk);
            ifc.imem_ack  = 1'b0;
         end else if (auto_ack && ifc.imem_req && !reset) begin
            a = int'(ifc.imem_addr);
            d = $urandom_range(1, 3);
            repeat (d) @(negedge clk);
            ifc.imem_ack  = 1'b1;
            ifc.imem_data = mem[a];
            ack_cyc       = cyc;
            @(negedge clk);
            ifc.imem_ack  = 1'b0;
         end
      end
   end

   // Monitor: compares every fetch request and every issue against the queues
   initial forever begin
      issue_t e;
      int     exp_addr;
      @(negedge clk);
      if (!reset) begin
         if (ifc.imem_req) begin
            if (fetch_q.size() == 0) begin
               chk("unexpected_fetch", 32'(ifc.imem_addr), 32'hFFFF_FFFF);
            end else begin
               exp_addr = fetch_q.pop_front();
               chk("imem_addr", 32'(ifc.imem_addr), 32'(exp_addr));
            end
            if (gap_pending) begin
               chk("issue_to_fetch_gap", 32'(cyc - issue_cyc), 32'(gap_exp));
               gap_pending = 1'b0;
            end
         end
         if (ifc.issue_valid) begin
            $display("issue pc=%02h opcode=%04h operand=%04h read_enable=%0b",
                     pc, ifc.opcode, ifc.operand, ifc.read_enable);
            if (issue_q.size() == 0) begin
               chk("unexpected_issue", 32'(ifc.opcode), 32'hFFFF_FFFF);
            end else begin
               e = issue_q.pop_front();
               chk("opcode", 32'(ifc.opcode), 32'(e.opc));
               chk("operand", 32'(ifc.operand), 32'(e.opd));
               chk("read_enable", 32'(ifc.read_enable), 32'(e.re));
               chk("ack_to_issue", 32'(cyc - ack_cyc), 32'h2);
               gap_pending = 1'b1;
               gap_exp     = e.gap;
               issue_cyc   = cyc;
            end
         end else begin
            chk("idle_outputs", {ifc.opcode, ifc.operand[14:0], ifc.read_enable},
                {16'hF100, 16'h0});
         end
      end
   end

   initial begin
      int          t0;
      int          n;
      int          len;
      int          tgt;
      int          k;
      logic [31:0] w;

      ifc.alu_flags = 4'h0;
      reset_dut(1'b1);

      // reset while waiting for the fetch; a late ack must be ignored
      fill_halt();
      auto_ack = 1'b0;
      fetch_q.push_back(0);
      start_pulse();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      inject_ack = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_ack_pc", 32'(pc), 32'h0);
      chk("late_ack_opcode", 32'(ifc.opcode), 32'hF100);
      chk("late_ack_issue_valid", 32'(ifc.issue_valid), 32'h0);
      chk("late_ack_busy", 32'(busy), 32'h0);
      repeat (4) @(negedge clk);
      chk("late_ack_still_idle", 32'(busy), 32'h0);
      fetch_q.delete();

      // directed program: LDI, ALU, taken JZ, RD, JMP to 0xFF, NOP, wrap, HALT
      reset_dut(1'b0);
      fill_halt();
      put(8'h00, 32'h0003_00AB);
      put(8'h01, 32'h1002_0100);
      put(8'h02, 32'hD000_0010);
      put(8'h10, 32'h2000_0005);
      put(8'h11, 32'hE000_00FF);
      put(8'hFF, 32'hF100_0000);
      flags_val = 4'b0001;
      ifc.alu_flags = flags_val;
      model_run(0, 1);
      ref_mem[0] = W_HALT;
      model_run(1, 100);
      auto_ack = 1'b1;
      start_pulse();
      n = 0;
      while (!ifc.issue_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("first_issue_seen", 32'(ifc.issue_valid), 32'h1);
      mem[0] = W_HALT;
      wait_halted(2000);
      chk("dir_busy", 32'(busy), 32'h0);
      chk("dir_error", 32'(error), 32'h0);
      chk("dir_final_pc", 32'(pc), 32'h0);
      check_drained();

      // JZ not taken falls through to pc+1
      reset_dut(1'b0);
      fill_halt();
      put(8'h00, 32'h0003_00AB);
      put(8'h01, 32'h1002_0100);
      put(8'h02, 32'hD000_0010);
      put(8'h10, 32'h2000_0005);
      flags_val = 4'b0000;
      ifc.alu_flags = flags_val;
      model_run(0, 100);
      start_pulse();
      wait_halted(2000);
      chk("jz_nt_pc", 32'(pc), 32'h3);
      check_drained();

      // fetch never acknowledged: timeout halt, then restart clears error
      reset_dut(1'b0);
      fill_halt();
      auto_ack = 1'b0;
      fetch_q.push_back(0);
      start_pulse();
      t0 = cyc;
      wait_halted(400);
      chk("timeout_latency_in_range", 32'((cyc - t0) >= 255 && (cyc - t0) <= 257), 32'h1);
      chk("timeout_error", 32'(error), 32'h1);
      chk("timeout_busy", 32'(busy), 32'h0);
      fetch_q.push_back(0);
      start_pulse();
      chk("restart_req", 32'(ifc.imem_req), 32'h1);
      chk("restart_addr", 32'(ifc.imem_addr), 32'h0);
      chk("restart_error", 32'(error), 32'h0);
      chk("restart_halted", 32'(halted), 32'h0);

      // random forward-only programs that always end in HALT
      for (int it = 0; it < 8; it++) begin
         reset_dut(1'b0);
         fill_halt();
         len = $urandom_range(6, 40);
         for (int i = 0; i < len - 1; i++) begin
            k   = $urandom_range(0, 5);
            tgt = $urandom_range(i + 1, len - 1);
            case (k)
               0:       w = {4'h0, 12'($urandom), 16'($urandom)};
               1:       w = {4'h1, 12'($urandom), 16'($urandom)};
               2:       w = {4'h2, 12'($urandom), 16'($urandom)};
               3:       w = {4'hD, 12'($urandom), 8'($urandom), 8'(tgt)};
               4:       w = {4'hE, 12'($urandom), 8'($urandom), 8'(tgt)};
               default: w = {4'hF, 4'($urandom_range(1, 15)), 8'($urandom), 16'($urandom)};
            endcase
            put(i, w);
         end
         put(len - 1, W_HALT);
         flags_val = 4'($urandom);
         ifc.alu_flags = flags_val;
         model_run(0, 1000);
         auto_ack = 1'b1;
         start_pulse();
         wait_halted(3000);
         chk("rand_error", 32'(error), 32'h0);
         check_drained();
      end

      auto_ack = 1'b0;
      reset_dut(1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
